stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control front end of the stopwatch: debounces the start/stop and lap/reset buttons, runs the run/pause/lap state machine, and divides the system clock down to the count-enable tick. Its `ci` output drives the carry-in of the least-significant stage of the BCD counter chain. Its `cnt_clr` output drives the `clr` of every stage. Its `hold` output freezes the display latch during lap view.

## Interface
- `DIV`, 500000: tick divisor in clk cycles (50 MHz to 100 Hz); must be ≥ 2.
- `DivBits`, 19: prescaler width; 2^DivBits ≥ DIV.
- `DB_CYCLES`, 1000000: debounce stability window in clk cycles (20 ms); must be ≥ 2.
- `DbBits`, 20: debounce counter width; 2^DbBits ≥ DB_CYCLES.

Ports:
- `clk` in 1: single system clock; all state updates on posedge.
- `clr` in 1: reset, synchronous, active-high.
- `btn_ss` in 1: raw start/stop button, asynchronous, active-high.
- `btn_lap` in 1: raw lap/reset button, asynchronous, active-high.
- `ci` out 1: count-enable pulse, one cycle wide, once per DIV cycles while counting.
- `cnt_clr` out 1: clear for the counter chain.
- `hold` out 1: display freeze, high in LAP.
- `running` out 1: high in RUN or LAP.

## Operation
- **Input path, per button:**
  - 2-flop synchronizer, then debouncer, then rising-edge detector.
  - Debouncer keeps a level `db` and a counter `dc`.
  - Each cycle with sync == `db`: `dc` ← 0.
  - Each cycle with sync != `db`: if `dc` == DB_CYCLES-1 then `db` ← sync and `dc` ← 0; otherwise `dc` ← `dc`+1.
  - A differing sync run shorter than DB_CYCLES cycles is ignored.
  - Press pulse = `db` & ~`db_d`, combinational, 1 cycle. Releases produce nothing.
- **FSM states:** IDLE (zeroed), RUN, LAP (counting, display held), STOP (paused).
  - IDLE: ss press → RUN. Lap press ignored.
  - RUN: ss press → STOP. Lap press → LAP.
  - LAP: ss press → STOP (hold released). Lap press → RUN.
  - STOP: ss press → RUN. Lap press → IDLE and assert the cnt_clr pulse.
  - Simultaneous ss and lap press in the same cycle: ss wins, lap press discarded.
- **Prescaler `pre` (DivBits):**
  - RUN/LAP: `pre` counts 0..DIV-1 and wraps to 0.
  - STOP: `pre` holds its value, so the fractional tick is preserved across a pause.
  - IDLE: `pre` ← 0.
- **Outputs:**
  - `ci` = `running` && (`pre` == DIV-1), combinational from registered state.
  - `running` = state ∈ {RUN, LAP}.
  - `hold` = state == LAP.
  - `cnt_clr` = `clr` | `clr_pulse`. `clr_pulse` is registered and high for exactly the one cycle after the STOP→IDLE edge.
- **Reset (`clr` high at a posedge):**
  - State ← IDLE; `pre`, all sync flops, `db`, `db_d`, `dc` and `clr_pulse` ← 0.
  - While `clr` is high: `ci`=0, `hold`=0, `running`=0, `cnt_clr`=1.
  - Reset mid-count or mid-debounce discards all progress. No press is generated by reset release, even if a button is held; the button must be released and re-pressed.

## Timing
- Button latency: a raw edge arriving before posedge 1 changes the FSM state at posedge DB_CYCLES+3.
  - Synchronized at edge 2.
  - `db` updates at edge DB_CYCLES+2.
  - Press pulse is high during the following cycle.
- Every state-dependent output is valid in the cycle after the transition edge.
- Entering RUN from IDLE at edge E: first `ci` high during the cycle after edge E+DIV-1, then every DIV cycles.
- Pause/resume: total `running` cycles between `ci` pulses is always DIV. Pause length does not affect tick phase.
- LAP affects only `hold`; `ci` cadence continues unchanged.
- `cnt_clr` pulse width is 1 cycle. It does not overlap `ci` because the state is IDLE.

## Test plan
Use DIV=5, DB_CYCLES=4.
1. **Reset:** hold `clr` 3 cycles with both buttons high → `cnt_clr`=1, all other outputs 0. After release, no state change until the buttons are released and re-pressed.
2. **Debounce:** `btn_ss` high 3 cycles then low → no transition. Held 8 cycles → state RUN at edge 7 after the raw edge; exactly one transition.
3. **Tick cadence:** from IDLE, press ss → `ci` pulses at cycles E+5, E+10, E+15 after entry, each 1 cycle wide.
4. **Pause/resume:** stop when `pre`=2, idle 20 cycles, resume → next `ci` after 2 more running cycles. `pre` is frozen while stopped.
5. **Lap and reset:** RUN, lap press → `hold`=1 and `ci` continues. Lap again → `hold`=0. Then ss press → STOP. Lap press → IDLE with `cnt_clr` high for exactly 1 cycle and `pre`=0.
6. **Simultaneous presses:** both buttons pressed in the same cycle in RUN → STOP, `hold`=0. Then `clr` asserted mid-debounce of a new press → no press is generated.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
//==========================================================================
// stopwatch_ctrl_if : button inputs and counter-chain control outputs
// Revision 1.0
//==========================================================================
interface stopwatch_ctrl_if;
  logic btn_ss;
  logic btn_lap;
  logic ci;
  logic cnt_clr;
  logic hold;
  logic running;

  modport master (
    output btn_ss,
    output btn_lap,
    input  ci,
    input  cnt_clr,
    input  hold,
    input  running
  );

  modport slave (
    input  btn_ss,
    input  btn_lap,
    output ci,
    output cnt_clr,
    output hold,
    output running
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
//==========================================================================
// stopwatch_ctrl : button debounce, run/pause/lap FSM and tick prescaler
// Revision 1.0
//==========================================================================
module stopwatch_ctrl #(
  parameter int DIV       = 500000,
  parameter int DivBits   = 19,
  parameter int DB_CYCLES = 1000000,
  parameter int DbBits    = 20
) (
  input  logic             clk,
  input  logic             clr,
  stopwatch_ctrl_if.slave  bus
);

  localparam int                 NBTN     = 2;
  localparam int                 BTN_SS   = 0;
  localparam int                 BTN_LAP  = 1;
  localparam logic [DivBits-1:0] PRE_LAST = DivBits'(DIV - 1);
  localparam logic [DbBits-1:0]  DC_LAST  = DbBits'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  logic [NBTN-1:0]    raw;
  logic [NBTN-1:0]    press;
  state_t             state;
  logic               running_q;
  logic               hold_q;
  logic               clr_pulse;
  logic [DivBits-1:0] pre;

  assign raw = {bus.btn_lap, bus.btn_ss};

  generate
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
      logic              sync1;
      logic              sync2;
      logic              db;
      logic              db_d;
      logic              armed;
      logic [1:0]        vld;
      logic [DbBits-1:0] dc;

      // armed only after a genuine low level is seen, so a button held
      // through reset must be released before it can produce a press
      always_ff @(posedge clk) begin
        if (clr) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
          db    <= 1'b0;
          db_d  <= 1'b0;
          armed <= 1'b0;
          vld   <= 2'b00;
          dc    <= '0;
        end else begin
          sync1 <= raw[gi];
          sync2 <= sync1;
          vld   <= {vld[0], 1'b1};
          db_d  <= db;
          if (vld[1] && !sync2) begin
            armed <= 1'b1;
          end
          if (sync2 == db) begin
            dc <= '0;
          end else if (dc == DC_LAST) begin
            db <= sync2;
            dc <= '0;
          end else begin
            dc <= dc + DbBits'(1);
          end
        end
      end

      assign press[gi] = db & ~db_d & armed;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      running_q <= 1'b0;
      hold_q    <= 1'b0;
      clr_pulse <= 1'b0;
    end else begin
      clr_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (press[BTN_SS]) begin
            state     <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (press[BTN_SS]) begin
            state     <= S_STOP;
            running_q <= 1'b0;
          end else if (press[BTN_LAP]) begin
            state  <= S_LAP;
            hold_q <= 1'b1;
          end
        end
        S_LAP: begin
          if (press[BTN_SS]) begin
            state     <= S_STOP;
            running_q <= 1'b0;
            hold_q    <= 1'b0;
          end else if (press[BTN_LAP]) begin
            state  <= S_RUN;
            hold_q <= 1'b0;
          end
        end
        S_STOP: begin
          if (press[BTN_SS]) begin
            state     <= S_RUN;
            running_q <= 1'b1;
          end else if (press[BTN_LAP]) begin
            state     <= S_IDLE;
            clr_pulse <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          running_q <= 1'b0;
          hold_q    <= 1'b0;
        end
      endcase
    end
  end

  // STOP keeps the fractional tick so a pause never shifts the tick phase
  always_ff @(posedge clk) begin
    if (clr) begin
      pre <= '0;
    end else begin
      case (state)
        S_RUN, S_LAP: pre <= (pre == PRE_LAST) ? '0 : pre + DivBits'(1);
        S_STOP:       pre <= pre;
        default:      pre <= '0;
      endcase
    end
  end

  assign bus.ci      = running_q && (pre == PRE_LAST);
  assign bus.running = running_q;
  assign bus.hold    = hold_q;
  assign bus.cnt_clr = clr | clr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
//==========================================================================
// tb_stopwatch_ctrl : directed self-checking bench, DIV=5, DB_CYCLES=4
// Revision 1.0
//==========================================================================
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic clr;
  int   n_cmp = 0;
  int   n_err = 0;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .DIV       (5),
    .DivBits   (3),
    .DB_CYCLES (4),
    .DbBits    (2)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // raw edge lands before posedge 1; the FSM moves on posedge 7
  task automatic press(input logic ss, input logic lap);
    bus.btn_ss  = ss;
    bus.btn_lap = lap;
    tick(7);
    bus.btn_ss  = 1'b0;
    bus.btn_lap = 1'b0;
  endtask

  task automatic test_reset();
    bus.btn_ss  = 1'b1;
    bus.btn_lap = 1'b1;
    clr = 1'b1;
    tick(3);
    n_cmp++; if (bus.cnt_clr !== 1'b1) begin n_err++; $display("FAIL rst_cnt_clr got %b want 1", bus.cnt_clr); end
    n_cmp++; if (bus.ci !== 1'b0) begin n_err++; $display("FAIL rst_ci got %b want 0", bus.ci); end
    n_cmp++; if (bus.hold !== 1'b0) begin n_err++; $display("FAIL rst_hold got %b want 0", bus.hold); end
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL rst_running got %b want 0", bus.running); end
    clr = 1'b0;
    tick(1);
    n_cmp++; if (bus.cnt_clr !== 1'b0) begin n_err++; $display("FAIL rst_release_cnt_clr got %b want 0", bus.cnt_clr); end
    tick(12);
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL rst_held_no_press got %b want 0", bus.running); end
    bus.btn_ss  = 1'b0;
    bus.btn_lap = 1'b0;
    tick(8);
  endtask

  task automatic test_debounce();
    bus.btn_ss = 1'b1;
    tick(3);
    bus.btn_ss = 1'b0;
    tick(8);
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL db_short_glitch got %b want 0", bus.running); end
    bus.btn_ss = 1'b1;
    tick(6);
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL db_edge6 got %b want 0", bus.running); end
    tick(1);
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL db_edge7 got %b want 1", bus.running); end
    tick(1);
    bus.btn_ss = 1'b0;
    tick(10);
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL db_single_transition got %b want 1", bus.running); end
  endtask

  task automatic test_tick_cadence();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(4);
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL cad_idle got %b want 0", bus.running); end
    press(1'b1, 1'b0);
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL cad_enter_run got %b want 1", bus.running); end
    n_cmp++; if (bus.ci !== 1'b0) begin n_err++; $display("FAIL cad_ci_entry got %b want 0", bus.ci); end
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      n_cmp++;
      if (bus.ci !== ((k % 5) == 4)) begin
        n_err++;
        $display("FAIL cad_ci_k%0d got %b want %b", k, bus.ci, ((k % 5) == 4));
      end
    end
  endtask

  task automatic test_pause_resume();
    press(1'b1, 1'b0);
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL pause_stop got %b want 0", bus.running); end
    for (int k = 0; k < 20; k++) begin
      tick(1);
      n_cmp++; if (bus.ci !== 1'b0) begin n_err++; $display("FAIL pause_ci_k%0d got %b want 0", k, bus.ci); end
    end
    press(1'b1, 1'b0);
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL resume_run got %b want 1", bus.running); end
    n_cmp++; if (bus.ci !== 1'b0) begin n_err++; $display("FAIL resume_ci0 got %b want 0", bus.ci); end
    tick(1);
    n_cmp++; if (bus.ci !== 1'b0) begin n_err++; $display("FAIL resume_ci1 got %b want 0", bus.ci); end
    tick(1);
    n_cmp++; if (bus.ci !== 1'b1) begin n_err++; $display("FAIL resume_ci2 got %b want 1", bus.ci); end
    tick(1);
    n_cmp++; if (bus.ci !== 1'b0) begin n_err++; $display("FAIL resume_ci3 got %b want 0", bus.ci); end
    tick(4);
    n_cmp++; if (bus.ci !== 1'b1) begin n_err++; $display("FAIL resume_ci7 got %b want 1", bus.ci); end
  endtask

  task automatic test_lap_reset();
    press(1'b0, 1'b1);
    n_cmp++; if (bus.hold !== 1'b1) begin n_err++; $display("FAIL lap_hold got %b want 1", bus.hold); end
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL lap_running got %b want 1", bus.running); end
    tick(3);
    n_cmp++; if (bus.ci !== 1'b1) begin n_err++; $display("FAIL lap_ci_continues got %b want 1", bus.ci); end
    tick(4);
    press(1'b0, 1'b1);
    n_cmp++; if (bus.hold !== 1'b0) begin n_err++; $display("FAIL lap_release_hold got %b want 0", bus.hold); end
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL lap_back_run got %b want 1", bus.running); end
    tick(7);
    press(1'b1, 1'b0);
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL lap_stop got %b want 0", bus.running); end
    n_cmp++; if (bus.cnt_clr !== 1'b0) begin n_err++; $display("FAIL lap_stop_cnt_clr got %b want 0", bus.cnt_clr); end
    tick(7);
    press(1'b0, 1'b1);
    n_cmp++; if (bus.cnt_clr !== 1'b1) begin n_err++; $display("FAIL clrp_high got %b want 1", bus.cnt_clr); end
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL clrp_idle got %b want 0", bus.running); end
    tick(1);
    n_cmp++; if (bus.cnt_clr !== 1'b0) begin n_err++; $display("FAIL clrp_width got %b want 0", bus.cnt_clr); end
    tick(6);
    press(1'b1, 1'b0);
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL restart_run got %b want 1", bus.running); end
    n_cmp++; if (bus.ci !== 1'b0) begin n_err++; $display("FAIL restart_pre0 got %b want 0", bus.ci); end
    tick(3);
    n_cmp++; if (bus.ci !== 1'b0) begin n_err++; $display("FAIL restart_ci3 got %b want 0", bus.ci); end
    tick(1);
    n_cmp++; if (bus.ci !== 1'b1) begin n_err++; $display("FAIL restart_ci4 got %b want 1", bus.ci); end
    tick(3);
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b1);
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL both_stop got %b want 0", bus.running); end
    n_cmp++; if (bus.hold !== 1'b0) begin n_err++; $display("FAIL both_hold got %b want 0", bus.hold); end
    tick(10);
    bus.btn_ss = 1'b1;
    tick(3);
    clr = 1'b1;
    tick(2);
    n_cmp++; if (bus.cnt_clr !== 1'b1) begin n_err++; $display("FAIL midrst_cnt_clr got %b want 1", bus.cnt_clr); end
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL midrst_running got %b want 0", bus.running); end
    clr = 1'b0;
    tick(12);
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL midrst_no_press got %b want 0", bus.running); end
    bus.btn_ss = 1'b0;
    tick(8);
    press(1'b1, 1'b0);
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL midrst_repress got %b want 1", bus.running); end
  endtask

  initial begin
    clr         = 1'b1;
    bus.btn_ss  = 1'b0;
    bus.btn_lap = 1'b0;
    test_reset();
    test_debounce();
    test_tick_cadence();
    test_pause_resume();
    test_lap_reset();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
